// File: rtl/led_pwm_pkg.sv
// Shared encodings for the multi-channel LED PWM fader.
// Mode values match the cfg_mode port encoding.
package led_pwm_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_STATIC  = 2'b01;
    localparam logic [1:0] MODE_FADE    = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    typedef enum logic [1:0] {
        ST_OFF     = MODE_OFF,
        ST_STATIC  = MODE_STATIC,
        ST_FADE    = MODE_FADE,
        ST_BREATHE = MODE_BREATHE
    } mode_t;

    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: mode FSM, level ramp, period-aligned duty
// shadow and the output compare against the shared counter.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_level,
    input  logic                tick,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] LVL_ZERO = '0;
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;

    mode_t               mode, mode_n;
    logic [PWM_BITS-1:0] cur, cur_n;
    logic [PWM_BITS-1:0] target, target_n;
    logic [PWM_BITS-1:0] duty;
    logic                dir, dir_n;
    logic                busy_n;

    // A write takes priority over a tick arriving in the same cycle
    always_comb begin
        mode_n   = mode;
        cur_n    = cur;
        target_n = target;
        dir_n    = dir;
        if (wr_en) begin
            mode_n   = mode_t'(wr_mode);
            target_n = wr_level;
            unique case (mode_t'(wr_mode))
                ST_OFF:    cur_n = LVL_ZERO;
                ST_STATIC: cur_n = wr_level;
                ST_FADE:   ;
                ST_BREATHE: begin
                    if (mode != ST_BREATHE)
                        dir_n = (cur < wr_level) ? DIR_UP : DIR_DOWN;
                    else if (wr_level < cur)
                        dir_n = DIR_DOWN;
                end
            endcase
        end else begin
            unique case (mode)
                ST_OFF:    cur_n = LVL_ZERO;
                ST_STATIC: cur_n = target;
                ST_FADE: begin
                    if (tick) begin
                        if (cur < target)
                            cur_n = cur + 1'b1;
                        else if (cur > target)
                            cur_n = cur - 1'b1;
                    end
                end
                ST_BREATHE: begin
                    if (tick) begin
                        if (dir == DIR_UP) begin
                            if (cur < target && cur != LVL_MAX) begin
                                cur_n = cur + 1'b1;
                            end else begin
                                dir_n = DIR_DOWN;
                                if (cur != LVL_ZERO)
                                    cur_n = cur - 1'b1;
                            end
                        end else begin
                            if (cur != LVL_ZERO) begin
                                cur_n = cur - 1'b1;
                            end else begin
                                dir_n = DIR_UP;
                                if (target != LVL_ZERO)
                                    cur_n = cur + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
        unique case (mode_n)
            ST_FADE:    busy_n = (cur_n != target_n);
            ST_BREATHE: busy_n = (target_n != LVL_ZERO);
            default:    busy_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode    <= ST_OFF;
            cur     <= LVL_ZERO;
            target  <= LVL_ZERO;
            dir     <= DIR_UP;
            duty    <= LVL_ZERO;
            busy    <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            mode    <= mode_n;
            cur     <= cur_n;
            target  <= target_n;
            dir     <= dir_n;
            busy    <= busy_n;
            if (wrap)
                duty <= cur;
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/rgb_pwm_fader.sv
// Multi-channel LED PWM fader: shared period counter, fade
// prescaler and config decode feeding per-channel engines.
module rgb_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8,
    parameter int DIV_BITS = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [chan_bits(CHANNELS)-1:0] cfg_chan,
    input  logic [1:0]                     cfg_mode,
    input  logic [PWM_BITS-1:0]            cfg_level,
    input  logic [DIV_BITS-1:0]            step_div,
    output logic [CHANNELS-1:0]            pwm_out,
    output logic [CHANNELS-1:0]            busy
);

    localparam int CW = chan_bits(CHANNELS);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_BITS-1:0] presc;
    logic                tick;
    logic                wrap;
    logic                cfg_fire;

    assign tick     = (presc == '0);
    assign wrap     = (pwm_cnt == '1);
    assign cfg_fire = cfg_valid & cfg_ready;

    // step_div is only sampled on reload, so changes land cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready <= 1'b0;
            pwm_cnt   <= '0;
            presc     <= '0;
        end else begin
            cfg_ready <= 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            if (tick)
                presc <= step_div;
            else
                presc <= presc - 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr_en;

        assign wr_en = cfg_fire && (cfg_chan == CW'(i));

        led_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en),
            .wr_mode (cfg_mode),
            .wr_level(cfg_level),
            .tick    (tick),
            .wrap    (wrap),
            .pwm_cnt (pwm_cnt),
            .pwm_out (pwm_out[i]),
            .busy    (busy[i])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with 3 channels, 8-bit PWM.
// Inputs change and outputs are sampled on the falling edge.
module tb_rgb_pwm_fader;
    import led_pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chan;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_level;
    logic [15:0] step_div;
    logic [2:0] pwm_out;
    logic [2:0] busy;

    always #5 clk = ~clk;

    rgb_pwm_fader #(
        .CHANNELS(3),
        .PWM_BITS(8),
        .DIV_BITS(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_mode (cfg_mode),
        .cfg_level(cfg_level),
        .step_div (step_div),
        .pwm_out  (pwm_out),
        .busy     (busy)
    );

    // Reference period counter, equal to the DUT counter at negedge
    logic [7:0] tb_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tb_cnt <= 8'd0;
        else
            tb_cnt <= tb_cnt + 8'd1;
    end

    logic [7:0] cur0, cur1, cur2;
    assign cur0 = dut.g_ch[0].u_ch.cur;
    assign cur1 = dut.g_ch[1].u_ch.cur;
    assign cur2 = dut.g_ch[2].u_ch.cur;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input logic [1:0] m, input int lvl);
        cfg_valid = 1'b1;
        cfg_chan  = 2'(ch);
        cfg_mode  = m;
        cfg_level = 8'(lvl);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tb_cnt != 8'(v) && k < 300);
        if (tb_cnt != 8'(v))
            chk("wait_cnt", int'(tb_cnt), v);
    endtask

    // Starts at the negedge where tb_cnt==1: covers PWM slots 0..255
    task automatic measure(output int h0, output int h1, output int h2);
        h0 = 0;
        h1 = 0;
        h2 = 0;
        for (int i = 0; i < 256; i++) begin
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
            @(negedge clk);
        end
    endtask

    initial begin
        int h0, h1, h2;
        int bad, prev, steps, last, gapbad, busybad, done_at;
        int bseq [10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = 2'd0;
        cfg_mode  = MODE_OFF;
        cfg_level = 8'd0;
        step_div  = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(cfg_ready), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_busy", int'(busy), 0);

        rst_n = 1'b1;
        #1;
        chk("ready_at_release", int'(cfg_ready), 0);
        @(negedge clk);
        chk("ready_rise", int'(cfg_ready), 1);
        bad = 0;
        repeat (512) begin
            @(negedge clk);
            if (pwm_out !== 3'b000 || busy !== 3'b000 || cfg_ready !== 1'b1)
                bad++;
        end
        chk("idle_512", bad, 0);

        // Static level on ch1
        wr(1, MODE_STATIC, 64);
        wait_cnt(255);
        wait_cnt(1);
        measure(h0, h1, h2);
        chk("t2_ch1_high", h1, 64);
        chk("t2_ch0_high", h0, 0);
        chk("t2_ch2_high", h2, 0);

        // Fade ch0 to 10, one step every 4 cycles
        step_div = 16'd3;
        repeat (6) @(negedge clk);
        wr(0, MODE_FADE, 10);
        chk("t3_busy_start", int'(busy[0]), 1);
        chk("t3_cur_start", int'(cur0), 0);
        prev = 0; steps = 0; last = -1;
        gapbad = 0; busybad = 0; done_at = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (int'(cur0) != prev) begin
                steps++;
                if (int'(cur0) != prev + 1)
                    gapbad++;
                if (last >= 0 && c - last != 4)
                    gapbad++;
                last = c;
                prev = int'(cur0);
            end
            if (busy[0] !== (cur0 != 8'd10))
                busybad++;
            if (cur0 == 8'd10 && done_at < 0)
                done_at = c;
        end
        chk("t3_steps", steps, 10);
        chk("t3_step_gap", gapbad, 0);
        chk("t3_busy_track", busybad, 0);
        chk("t3_done_window", int'(done_at >= 37 && done_at <= 40), 1);
        wait_cnt(255);
        wait_cnt(1);
        measure(h0, h1, h2);
        chk("t3_duty0", h0, 10);
        chk("t3_duty1", h1, 64);

        // Breathe ch2 up to 4, one step per cycle
        step_div = 16'd0;
        repeat (6) @(negedge clk);
        wr(2, MODE_BREATHE, 4);
        busybad = 0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4_cur_%0d", i), int'(cur2), bseq[i]);
            if (busy[2] !== 1'b1)
                busybad++;
            @(negedge clk);
        end
        chk("t4_busy", busybad, 0);

        // Two level changes inside one period
        wait_cnt(255);
        wait_cnt(1);
        h1 = 0;
        for (int i = 0; i < 256; i++) begin
            h1 += int'(pwm_out[1]);
            cfg_valid = 1'b0;
            if (tb_cnt == 8'd50 || tb_cnt == 8'd100) begin
                cfg_valid = 1'b1;
                cfg_chan  = 2'd1;
                cfg_mode  = MODE_STATIC;
                cfg_level = (tb_cnt == 8'd50) ? 8'd200 : 8'd20;
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        chk("t5_old_period", h1, 64);
        measure(h0, h1, h2);
        chk("t5_new_period", h1, 20);
        chk("t5_ch0", h0, 10);

        // Out-of-range channel write and full-scale duty
        wr(2, MODE_OFF, 0);
        wr(1, MODE_STATIC, 255);
        wr(3, MODE_STATIC, 77);
        repeat (2) @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_cur0", int'(cur0), 10);
        chk("t6_cur1", int'(cur1), 255);
        chk("t6_cur2", int'(cur2), 0);
        wait_cnt(255);
        wait_cnt(1);
        measure(h0, h1, h2);
        chk("t6_duty0", h0, 10);
        chk("t6_duty_max", h1, 255);
        chk("t6_duty2", h2, 0);

        // Write on a tick cycle: the tick is dropped
        wr(0, MODE_FADE, 200);
        chk("t6_wr_tick_cur", int'(cur0), 10);
        chk("t6_wr_tick_busy", int'(busy[0]), 1);
        @(negedge clk);
        chk("t6_after_tick", int'(cur0), 11);
        @(negedge clk);
        chk("t6_mid_fade", int'(busy[0]), 1);

        // Asynchronous reset mid-fade
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pwm", int'(pwm_out), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_ready", int'(cfg_ready), 0);
        chk("t6_rst_cur0", int'(cur0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_again", int'(cfg_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
Parametrised multi-channel LED PWM controller, the successor to the free-running gray-counter blinky.
- Each channel has its own brightness level and mode: static, fade-to-target, breathe or off.
- Levels can be written at runtime through a valid/ready config port.
- pwm_out feeds the PWM inputs of the iCE40 SB_RGBA_DRV (or GPIO) in the top level; the driver stays outside this block.

Parameters:
CHANNELS, 3, number of independent PWM channels (1..8)
PWM_BITS, 8, PWM resolution; period = 2^PWM_BITS clk cycles
DIV_BITS, 16, width of the fade-step prescaler

Ports:
clk  in  1  system clock (12 MHz oscillator)
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high together with cfg_valid
cfg_chan  in  max(1,$clog2(CHANNELS))  target channel index
cfg_mode  in  2  00 OFF, 01 STATIC, 10 FADE, 11 BREATHE
cfg_level  in  PWM_BITS  target/peak brightness
step_div  in  DIV_BITS  fade step period minus 1, in clk cycles
pwm_out  out  CHANNELS  PWM output per channel
busy  out  CHANNELS  per channel: 1 while the level is still moving

Behaviour:
- Reset (async assert, sync release):
  - pwm_cnt=0, prescaler=0.
  - All channels: mode OFF, cur=0, target=0, duty=0, dir=up.
  - pwm_out=0, busy=0, cfg_ready=0.
  - cfg_ready rises 1 cycle after rst_n deasserts and then stays 1.
- Config handshake:
  - A write fires on cfg_valid & cfg_ready; one write per cycle.
  - It captures mode and target for cfg_chan, and takes effect the next cycle.
  - cfg_chan >= CHANNELS: write accepted and ignored.
- PWM counter: PWM_BITS free-running, wraps from 2^PWM_BITS-1 to 0.
- Duty shadow: duty[i] <= cur[i] only on the cycle pwm_cnt==2^PWM_BITS-1. This makes changes glitch-free, applied at a period start.
- Output: pwm_out[i] is registered as (pwm_cnt < duty[i]).
  - duty=0 gives constant low.
  - Max duty gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- Prescaler and step tick:
  - When the prescaler is 0: tick=1 and it reloads with step_div; otherwise it decrements.
  - step_div=0 gives a tick every cycle.
  - A new step_div value takes effect at the next reload.
- Per-channel mode FSM; cur is updated on the cycle after a tick:
  - OFF: cur=0 immediately; busy=0.
  - STATIC: cur=target immediately; busy=0.
  - FADE: each tick, cur moves 1 LSB toward target. busy=(cur!=target); it goes low on the cycle cur reaches target.
  - BREATHE: ramp in dir by 1 per tick. Direction reverses when cur==target (going up) or cur==0 (going down). busy=1 whenever target != 0.
    - Sequence with target=4: 0,1,2,3,4,3,2,1,0,1,...
    - target=0: cur holds 0 and busy=0.
    - Entering BREATHE: dir=up if cur<target, else down.
    - A new target below cur forces dir=down.
- Arithmetic:
  - cur saturates at 0 and at 2^PWM_BITS-1; no wrap-around.
  - All comparisons are unsigned.
- Simultaneous config write and tick on the same channel: the write wins and the tick is dropped for that channel only.
- Reset mid-fade or mid-breathe: everything returns to reset values within the same cycle (async).

Decomposition:
- Package led_pwm_pkg:
  - Mode encoding localparams: MODE_OFF, MODE_STATIC, MODE_FADE, MODE_BREATHE.
  - Dir constants.
- Sub-module led_pwm_channel:
  - Contains the per-channel cur/target/dir/duty registers, the mode FSM and the output compare.
  - Instantiated CHANNELS times via generate.
  - pwm_cnt, the wrap strobe, tick and the config decode stay in the top level.

Test Plan:
1. Reset release -> cfg_ready goes 0 then 1 on the next cycle; pwm_out=000 and busy=000 for 512 cycles.
2. Write ch1 STATIC level 64 -> from the next PWM period, pwm_out[1] is high for exactly 64 of every 256 cycles; ch0 and ch2 stay low.
3. Write ch0 FADE target 10 with step_div=3, starting from cur=0 -> busy[0]=1, cur increments every 4 cycles and reaches 10 after 40 cycles; busy[0] falls, and the duty shows 10 from the next period wrap.
4. Write ch2 BREATHE target 4 with step_div=0 -> cur sequence 0,1,2,3,4,3,2,1,0,1 on consecutive cycles; busy[2] stays 1.
5. Write STATIC 200 at pwm_cnt=50, then STATIC 20 at pwm_cnt=100 in the same period -> the current period keeps its old duty; the next period shows duty 20 only (no mid-period glitch).
6. Edge cases:
   - Assert rst_n low mid-fade -> all outputs are 0 immediately.
   - A write to cfg_chan=3 with CHANNELS=3 -> no channel changes.
   - A write coincident with a tick -> the written value wins.
